// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-subset datapath.
// Sequences fetch/decode/execute/writeback and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0]  state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        functLegal;
  logic [2:0]  functAlu;
  logic        opcodeLegal;
  logic        retireNow;

  always_comb begin
    functLegal = 1'b1;
    functAlu   = ALU_ADD;
    case (funct)
      FN_ADD:  functAlu = ALU_ADD;
      FN_SUB:  functAlu = ALU_SUB;
      FN_AND:  functAlu = ALU_AND;
      FN_OR:   functAlu = ALU_OR;
      FN_SLT:  functAlu = ALU_SLT;
      default: functLegal = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcodeLegal = 1'b1;
      OP_RTYPE:                            opcodeLegal = functLegal;
      default:                             opcodeLegal = 1'b0;
    endcase
  end

  // Unused encodings 12-15 fall through the default arm and recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = functLegal ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retireNow = 1'b1;
      S_MEMWRITE:                                   retireNow = mem_ready;
      default:                                      retireNow = 1'b0;
    endcase
  end

  assign retired_d = retired_q + {31'd0, retireNow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Reset overrides only the strobes that could disturb memory, PC or registers.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_AND;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        illegal     = ~opcodeLegal;
      end
      S_MEMADR, S_ADDIEXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = functAlu;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step queues the expected
// state/control/retired triple and the DUT response is popped and compared.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0]  pc_src;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;

  logic [16:0] cFetchWait, cFetchGo, cFetchRst, cDecode, cDecodeIll, cAddr;
  logic [16:0] cMemRd, cMemRdRst, cMemWr, cMemWb, cAddiWb, cExecSlt, cAluWb;
  logic [16:0] cBrTaken, cBrNot, cJump;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .illegal     (illegal),
    .state       (state),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout: memReq memWrite iord irWrite pcEn pcSrc regWrite
  // regDst memToReg aluSrcA aluSrcB aluControl illegal.
  function automatic logic [16:0] mk(input logic mr, input logic mw, input logic io,
                                     input logic irw, input logic pe, input logic [1:0] ps,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [2:0] alu, input logic ill);
    return {mr, mw, io, irw, pe, ps, rw, rd, m2r, asa, asb, alu, ill};
  endfunction

  task automatic checkOutput();
    exp_t        e;
    logic [16:0] obsCtrl;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    obsCtrl = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control, illegal};
    compared++;
    assert (state === e.st) else begin
      mismatched++;
      $error("[TB] FAIL %s.state: observed %0d expected %0d", e.tag, state, e.st);
    end
    compared++;
    assert (obsCtrl === e.ctrl) else begin
      mismatched++;
      $error("[TB] FAIL %s.ctrl: observed %b expected %b", e.tag, obsCtrl, e.ctrl);
    end
    compared++;
    assert (retired === e.ret) else begin
      mismatched++;
      $error("[TB] FAIL %s.retired: observed %h expected %h", e.tag, retired, e.ret);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic [5:0] op,
                               input logic [5:0] fn, input logic z, input logic rdy,
                               input logic [3:0] expSt, input logic [16:0] expCtrl,
                               input logic [31:0] expRet);
    exp_t e;
    @(negedge clk);
    rst       = r;
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = rdy;
    e.tag  = tag;
    e.st   = expSt;
    e.ctrl = expCtrl;
    e.ret  = expRet;
    sb.push_back(e);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    cFetchWait = mk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,3'b010,0);
    cFetchGo   = mk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,3'b010,0);
    cFetchRst  = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b01,3'b010,0);
    cDecode    = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,3'b010,0);
    cDecodeIll = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,3'b010,1);
    cAddr      = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,3'b010,0);
    cMemRd     = mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0);
    cMemRdRst  = mk(0,0,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0);
    cMemWr     = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0);
    cMemWb     = mk(0,0,0,0,0,2'b00,1,0,1,0,2'b00,3'b000,0);
    cAddiWb    = mk(0,0,0,0,0,2'b00,1,0,0,0,2'b00,3'b000,0);
    cExecSlt   = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,3'b111,0);
    cAluWb     = mk(0,0,0,0,0,2'b00,1,1,0,0,2'b00,3'b000,0);
    cBrTaken   = mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,3'b110,0);
    cBrNot     = mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,3'b110,0);
    cJump      = mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,3'b000,0);

    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus("reset",        1, OP_LW,   6'd0,      0, 1, 4'd0,  cFetchRst,  32'd0);
    // lw with memory always ready
    applyStimulus("lw.fetch",     0, OP_LW,   6'd0,      0, 1, 4'd0,  cFetchGo,   32'd0);
    applyStimulus("lw.decode",    0, OP_LW,   6'd0,      0, 1, 4'd1,  cDecode,    32'd0);
    applyStimulus("lw.memadr",    0, OP_LW,   6'd0,      0, 1, 4'd2,  cAddr,      32'd0);
    applyStimulus("lw.memread",   0, OP_LW,   6'd0,      0, 1, 4'd3,  cMemRd,     32'd0);
    applyStimulus("lw.memwb",     0, OP_LW,   6'd0,      0, 1, 4'd4,  cMemWb,     32'd0);
    // sw with three wait cycles in MEMWRITE
    applyStimulus("sw.fetch",     0, OP_SW,   6'd0,      0, 1, 4'd0,  cFetchGo,   32'd1);
    applyStimulus("sw.decode",    0, OP_SW,   6'd0,      0, 1, 4'd1,  cDecode,    32'd1);
    applyStimulus("sw.memadr",    0, OP_SW,   6'd0,      0, 1, 4'd2,  cAddr,      32'd1);
    applyStimulus("sw.wait0",     0, OP_SW,   6'd0,      0, 0, 4'd5,  cMemWr,     32'd1);
    applyStimulus("sw.wait1",     0, OP_SW,   6'd0,      0, 0, 4'd5,  cMemWr,     32'd1);
    applyStimulus("sw.wait2",     0, OP_SW,   6'd0,      0, 0, 4'd5,  cMemWr,     32'd1);
    applyStimulus("sw.done",      0, OP_SW,   6'd0,      0, 1, 4'd5,  cMemWr,     32'd1);
    applyStimulus("fetch.wait",   0, OP_BEQ,  6'd0,      0, 0, 4'd0,  cFetchWait, 32'd2);
    // beq taken then not taken
    applyStimulus("beq1.fetch",   0, OP_BEQ,  6'd0,      1, 1, 4'd0,  cFetchGo,   32'd2);
    applyStimulus("beq1.decode",  0, OP_BEQ,  6'd0,      1, 1, 4'd1,  cDecode,    32'd2);
    applyStimulus("beq1.branch",  0, OP_BEQ,  6'd0,      1, 1, 4'd8,  cBrTaken,   32'd2);
    applyStimulus("beq2.fetch",   0, OP_BEQ,  6'd0,      0, 1, 4'd0,  cFetchGo,   32'd3);
    applyStimulus("beq2.decode",  0, OP_BEQ,  6'd0,      0, 1, 4'd1,  cDecode,    32'd3);
    applyStimulus("beq2.branch",  0, OP_BEQ,  6'd0,      0, 1, 4'd8,  cBrNot,     32'd3);
    // R-type slt
    applyStimulus("slt.fetch",    0, OP_R,    6'b101010, 0, 1, 4'd0,  cFetchGo,   32'd4);
    applyStimulus("slt.decode",   0, OP_R,    6'b101010, 0, 1, 4'd1,  cDecode,    32'd4);
    applyStimulus("slt.execute",  0, OP_R,    6'b101010, 0, 1, 4'd6,  cExecSlt,   32'd4);
    applyStimulus("slt.aluwb",    0, OP_R,    6'b101010, 0, 1, 4'd7,  cAluWb,     32'd4);
    // addi
    applyStimulus("addi.fetch",   0, OP_ADDI, 6'd0,      0, 1, 4'd0,  cFetchGo,   32'd5);
    applyStimulus("addi.decode",  0, OP_ADDI, 6'd0,      0, 1, 4'd1,  cDecode,    32'd5);
    applyStimulus("addi.exec",    0, OP_ADDI, 6'd0,      0, 1, 4'd9,  cAddr,      32'd5);
    applyStimulus("addi.wb",      0, OP_ADDI, 6'd0,      0, 1, 4'd10, cAddiWb,    32'd5);
    // unsupported funct and unsupported opcode
    applyStimulus("badfn.fetch",  0, OP_R,    6'b000111, 0, 1, 4'd0,  cFetchGo,   32'd6);
    applyStimulus("badfn.decode", 0, OP_R,    6'b000111, 0, 1, 4'd1,  cDecodeIll, 32'd6);
    applyStimulus("badop.fetch",  0, OP_BAD,  6'd0,      0, 1, 4'd0,  cFetchGo,   32'd6);
    applyStimulus("badop.decode", 0, OP_BAD,  6'd0,      0, 1, 4'd1,  cDecodeIll, 32'd6);
    // reset during a MEMREAD wait
    applyStimulus("rlw.fetch",    0, OP_LW,   6'd0,      0, 1, 4'd0,  cFetchGo,   32'd6);
    applyStimulus("rlw.decode",   0, OP_LW,   6'd0,      0, 1, 4'd1,  cDecode,    32'd6);
    applyStimulus("rlw.memadr",   0, OP_LW,   6'd0,      0, 1, 4'd2,  cAddr,      32'd6);
    applyStimulus("rlw.wait",     0, OP_LW,   6'd0,      0, 0, 4'd3,  cMemRd,     32'd6);
    applyStimulus("rlw.rst",      1, OP_LW,   6'd0,      0, 1, 4'd3,  cMemRdRst,  32'd6);
    // jump with retired counter preloaded to all ones
    applyStimulus("j.fetch",      0, OP_J,    6'd0,      0, 1, 4'd0,  cFetchGo,   32'd0);
    applyStimulus("j.decode",     0, OP_J,    6'd0,      0, 1, 4'd1,  cDecode,    32'd0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    applyStimulus("j.jump",       0, OP_J,    6'd0,      0, 1, 4'd11, cJump,      32'hFFFF_FFFF);
    applyStimulus("j.wrap",       0, OP_J,    6'd0,      0, 0, 4'd0,  cFetchWait, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instr[31:26] taken from the instruction register.
REQ-005 funct  input  6  instr[5:0] taken from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current request in this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_write  output  1  write strobe, only valid with mem_req.
REQ-010 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 ir_write  output  1  load the instruction register.
REQ-012 pc_en  output  1  PC load enable.
REQ-013 pc_src  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-014 reg_write, reg_dst, mem_to_reg  output  1 each  register-file write controls; reg_dst 1 selects instr[15:11].
REQ-015 alu_src_a  output  1  ALU A select: 0=PC, 1=rd1.
REQ-016 alu_src_b  output  2  ALU B select: 00=rd2, 01=const 4, 10=imm, 11=imm<<2.
REQ-017 alu_control  output  3  ALU function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-018 illegal  output  1  one-cycle pulse when an instruction is unsupported.
REQ-019 state  output  4  current state encoding, for debug.
REQ-020 retired  output  32  count of completed instructions.

Function
REQ-021 The controller SHALL be a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-022 FETCH SHALL drive: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_src=00.
REQ-023 In FETCH, ir_write and pc_en SHALL be asserted only in the cycle with mem_ready=1, and the FSM SHALL advance to DECODE on that edge; otherwise it holds in FETCH.
REQ-024 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_control=ADD.
REQ-025 DECODE SHALL branch on opcode: 100011 (lw) and 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEXEC; 000010 (j) -> JUMP.
REQ-026 For any other opcode, or an R-type funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}, DECODE SHALL pulse illegal for one cycle and go to FETCH.
REQ-027 MEMADR and ADDIEXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_control=ADD; MEMADR then goes to MEMREAD (lw) or MEMWRITE (sw), and ADDIEXEC goes to ADDIWB.
REQ-028 MEMREAD SHALL drive mem_req=1, iord=1, hold until mem_ready=1, then go to MEMWB.
REQ-029 MEMWRITE SHALL drive mem_req=1, mem_write=1, iord=1, hold until mem_ready=1, then go to FETCH.
REQ-030 MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-031 ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-032 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, with alu_control decoded from funct (add->010, sub->110, and->000, or->001, slt->111), and go to ALUWB.
REQ-033 ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-034 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_control=SUB, pc_src=01, and pc_en=zero (combinational on zero).
REQ-035 JUMP SHALL drive pc_src=10 and pc_en=1.
REQ-036 MEMWB, ALUWB, ADDIWB, BRANCH and JUMP SHALL each last exactly one cycle, then go to FETCH.
REQ-037 Every output not listed for a state SHALL be 0 in that state.
REQ-038 Instruction latencies with mem_ready tied to 1 SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-039 retired SHALL increment by 1 on each edge leaving MEMWB, MEMWRITE (with mem_ready=1), ALUWB, ADDIWB, BRANCH or JUMP.
REQ-040 retired SHALL wrap from 0xFFFFFFFF to 0, and illegal instructions SHALL not be counted.
REQ-041 If mem_ready=1 outside FETCH, MEMREAD or MEMWRITE, it SHALL be ignored.

Reset
REQ-042 When rst=1 at a clock edge, state SHALL become FETCH and retired SHALL become 0.
REQ-043 While rst=1, mem_req, mem_write, ir_write, pc_en, reg_write and illegal SHALL be forced to 0, regardless of state or mem_ready.
REQ-044 Reset asserted mid-instruction, including while a memory wait is in progress, SHALL abandon the instruction without a register write and without incrementing retired.

Verification
REQ-045 lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4; reg_write in cycle 5 only; retired 0->1.
REQ-046 sw with mem_ready low for 3 cycles in MEMWRITE -> mem_req/mem_write held 4 cycles; state 5 held; single retire.
REQ-047 beq with zero=1, then beq with zero=0 -> pc_en=1 and pc_src=01 in BRANCH for the first; pc_en=0 for the second.
REQ-048 R-type funct 101010 -> alu_control=111 in EXECUTE; funct 000111 -> illegal pulse in DECODE, next state 0, retired unchanged.
REQ-049 rst asserted during MEMREAD wait -> next state 0; retired=0; no reg_write observed.
REQ-050 Force retired to 0xFFFFFFFF (via back-door preload), then execute j -> retired=0.
